fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Multi-cycle sequencer for the core's program counter and instruction fetch. Steps each instruction through FETCH, DECODE, EXEC and UPDATE, and handshakes with instruction memory and the execute stage. Drives the PC's increment, load and target inputs, holds the instruction register, and counts retired instructions. Sits between the pc block, the imem port and the execute unit.

Parameters:
PC_W, 4, PC width; must match the pc block.
INSTR_W, 8, instruction width; opcode is bits [INSTR_W-1 -: OPC_W].
OPC_W, 4, opcode field width.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  leaves IDLE/HALT and begins execution
halt_req  in  1  external stop request; takes effect at the next instruction boundary
imem_req  out  1  fetch request; held until ack
imem_ack  in  1  imem data valid this cycle
imem_data  in  INSTR_W  fetched instruction
ir  out  INSTR_W  instruction register
exec_valid  out  1  ir valid for execute; held until exec_done
exec_done  in  1  execute complete
br_taken  in  1  sampled with exec_done: redirect PC
br_tgt  in  PC_W  branch target, sampled with exec_done
pc_en  out  1  one-cycle PC increment pulse
pc_load  out  1  one-cycle PC load pulse
pc_tgt  out  PC_W  load value for the PC
halted  out  1  high in HALT
retire_cnt  out  CNT_W  retired-instruction count, saturating

Behaviour:
- All state is updated on the rising edge of clk. rst is synchronous, active-high, and overrides everything.
- Reset values: state=IDLE; ir=0; pc_tgt=0; retire_cnt=0; imem_req, exec_valid, pc_en, pc_load and halted all 0.
- Reset mid-operation: returns to IDLE on the next edge and drops imem_req/exec_valid immediately. A late imem_ack or exec_done arriving afterwards is ignored.
- IDLE: all outputs low. When start=1, go to FETCH.
- FETCH: imem_req=1. When imem_ack=1, latch ir<=imem_data and go to DECODE. Minimum time in FETCH is 1 cycle; there is no timeout.
- DECODE: 1 cycle.
  - If opcode==OP_HALT, go to HALT. retire_cnt is not incremented and pc is not changed.
  - Otherwise go to EXEC.
- EXEC: exec_valid=1. When exec_done=1, capture br_taken/br_tgt into internal regs and go to UPDATE.
- UPDATE: 1 cycle.
  - If the captured br_taken=1: pc_load=1 and pc_tgt=captured br_tgt.
  - Otherwise pc_en=1.
  - pc_load and pc_en are never asserted together.
  - retire_cnt increments by 1 and saturates at all-ones.
  - Next state is HALT if a halt is pending, else FETCH.
- HALT: halted=1. When start=1, go to FETCH; pending halt is cleared on entry.
- halt_req: sets a sticky pending flag in any state except IDLE/HALT. The flag is consumed in UPDATE. A current fetch or exec is never aborted.
- Latency: with zero-wait imem_ack and exec_done, one instruction takes 4 cycles (FETCH, DECODE, EXEC, UPDATE). The PC update is visible on the cycle after UPDATE.
- PC wrap-around is handled by the pc block (all-ones+1 -> 0). This block does not special-case it.
- Simultaneous start and halt_req in IDLE: start wins; halt_req is ignored while in IDLE.

Decomposition:
- Shared package (cpu_pkg): state encoding (IDLE, FETCH, DECODE, EXEC, UPDATE, HALT), OP_HALT=4'hF, OPC_W, INSTR_W defaults.
- One natural sub-module: retire_counter (saturating CNT_W counter with inc and sync clear). The FSM stays in fetch_ctrl.

Test Plan:
1. rst for 2 cycles, then idle with start=0 -> all outputs 0, state stays IDLE.
2. start pulse, imem_data=8'h12 with ack 1 cycle after req, exec_done 1 cycle after exec_valid, br_taken=0 -> ir=8'h12, a single pc_en pulse 4–5 cycles after start, retire_cnt=1, imem_req reasserted the next cycle.
3. exec_done=1, br_taken=1, br_tgt=4'hA -> in UPDATE: pc_load=1, pc_tgt=4'hA, pc_en=0; retire_cnt increments.
4. imem_data=8'hF0 -> DECODE goes to HALT; halted=1, no pc_en/pc_load pulse, retire_cnt unchanged; then start -> FETCH.
5. halt_req pulsed during EXEC with exec_done delayed 3 cycles -> exec completes, pc_en pulses, then HALT; no new imem_req.
6. rst asserted mid-FETCH while imem_ack arrives the same cycle -> next cycle IDLE, ir=0, imem_req=0; preload retire_cnt to 16'hFFFF and retire one more instruction -> count stays 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the sequencer state encoding, the HALT opcode and the default
// widths that the pc block, imem port and execute unit agree on.
package cpu_pkg;

    localparam int PC_W_DEF    = 4;
    localparam int INSTR_W_DEF = 8;
    localparam int OPC_W_DEF   = 4;
    localparam int CNT_W_DEF   = 16;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer and its neighbours: the imem
// port (req/ack/data), the execute unit (ir, valid/done, branch result)
// and the pc block (increment, load, target).
//   master : the sequencer side (drives req, ir, exec_valid, pc controls)
//   slave  : the memory / execute / pc side
interface fetch_ctrl_if #(
    parameter int PC_W    = cpu_pkg::PC_W_DEF,
    parameter int INSTR_W = cpu_pkg::INSTR_W_DEF
);
    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] ir;
    logic               exec_valid;
    logic               exec_done;
    logic               br_taken;
    logic [PC_W-1:0]    br_tgt;
    logic               pc_en;
    logic               pc_load;
    logic [PC_W-1:0]    pc_tgt;

    modport master (
        output imem_req, ir, exec_valid, pc_en, pc_load, pc_tgt,
        input  imem_ack, imem_data, exec_done, br_taken, br_tgt
    );

    modport slave (
        input  imem_req, ir, exec_valid, pc_en, pc_load, pc_tgt,
        output imem_ack, imem_data, exec_done, br_taken, br_tgt
    );
endinterface

// File: rtl/retire_counter.sv
// Saturating retired-instruction counter.
// Ports:
//   clk  - system clock
//   clr  - synchronous clear (active high)
//   inc  - add one this cycle; holds at all-ones once reached
//   cnt  - current count
module retire_counter #(
    parameter int CNT_W = cpu_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle program-counter / instruction-fetch sequencer.
// Walks each instruction through FETCH, DECODE, EXEC and UPDATE, handshaking
// with imem and the execute unit, and drives the pc block's increment/load.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   start      - leave IDLE/HALT and begin fetching
//   halt_req   - stop at the next instruction boundary
//   bus        - imem / execute / pc bundle (master side)
//   halted     - high while in HALT
//   retire_cnt - saturating count of retired instructions
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, everything quiet, waiting for start
// FETCH  | imem_req held until imem_ack; ir latched on ack
// DECODE | one cycle; HALT opcode stops here without retiring
// EXEC   | exec_valid held until exec_done; branch result captured
// UPDATE | one cycle; pc_load or pc_en pulse, retire count bumps
// HALT   | halted high, waiting for start
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    fetch_ctrl_if.master      bus,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt
);
    state_t          state, state_nxt;
    logic            halt_pend;
    logic            br_taken_q;
    logic [PC_W-1:0] br_tgt_q;
    logic            is_halt_op;
    logic            retire;

    assign is_halt_op = (bus.ir[INSTR_W-1 -: OPC_W] == OPC_W'(OP_HALT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request seen during UPDATE itself still stops at this boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  if (bus.imem_ack) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = is_halt_op ? ST_HALT : ST_EXEC;
            ST_EXEC:   if (bus.exec_done) state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = (halt_pend || halt_req) ? ST_HALT : ST_FETCH;
            ST_HALT:   if (start) state_nxt = ST_FETCH;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req   = 1'b0;
        bus.exec_valid = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_load    = 1'b0;
        halted         = 1'b0;
        retire         = 1'b0;
        case (state)
            ST_FETCH:  bus.imem_req   = 1'b1;
            ST_EXEC:   bus.exec_valid = 1'b1;
            ST_UPDATE: begin
                bus.pc_load = br_taken_q;
                bus.pc_en   = !br_taken_q;
                retire      = 1'b1;
            end
            ST_HALT:   halted = 1'b1;
            default:   ;
        endcase
    end

    // The pending flag only accumulates while an instruction is in flight;
    // it is consumed by UPDATE and never carried into IDLE/HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_pend <= 1'b0;
        end else if (state == ST_IDLE || state == ST_HALT || state == ST_UPDATE) begin
            halt_pend <= 1'b0;
        end else if (halt_req) begin
            halt_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ir     <= '0;
            br_taken_q <= 1'b0;
            br_tgt_q   <= '0;
        end else begin
            if (state == ST_FETCH && bus.imem_ack) begin
                bus.ir <= bus.imem_data;
            end
            if (state == ST_EXEC && bus.exec_done) begin
                br_taken_q <= bus.br_taken;
                br_tgt_q   <= bus.br_tgt;
            end
        end
    end

    assign bus.pc_tgt = br_tgt_q;

    retire_counter #(.CNT_W(CNT_W)) u_retire (
        .clk (clk),
        .clr (rst),
        .inc (retire),
        .cnt (retire_cnt)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt_req, halted;
    logic [15:0] retire_cnt;
    logic        start_s, halt_req_s, halted_s;
    logic [2:0]  retire_cnt_s;
    int          checks   = 0;
    int          failures = 0;

    fetch_ctrl_if #(.PC_W(4), .INSTR_W(8)) bus ();
    fetch_ctrl_if #(.PC_W(4), .INSTR_W(8)) bus_s ();

    fetch_ctrl #(.PC_W(4), .INSTR_W(8), .OPC_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt_req   (halt_req),
        .bus        (bus),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    // Narrow-counter instance, free-running with zero-wait handshakes,
    // used to reach counter saturation in a handful of instructions.
    fetch_ctrl #(.PC_W(4), .INSTR_W(8), .OPC_W(4), .CNT_W(3)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s),
        .halt_req   (halt_req_s),
        .bus        (bus_s),
        .halted     (halted_s),
        .retire_cnt (retire_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
        bus.exec_done = 1'b0; bus.br_taken = 1'b0; bus.br_tgt = 4'h0;
        start_s = 1'b0; halt_req_s = 1'b0;
        bus_s.imem_ack = 1'b1; bus_s.imem_data = 8'h12;
        bus_s.exec_done = 1'b1; bus_s.br_taken = 1'b0; bus_s.br_tgt = 4'h0;

        // 1: reset then idle
        step(2);
        rst = 1'b0;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_exec_valid", bus.exec_valid, 0);
        chk("rst_pc_en", bus.pc_en, 0);
        chk("rst_pc_load", bus.pc_load, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ir", bus.ir, 0);
        chk("rst_pc_tgt", bus.pc_tgt, 0);
        chk("rst_retire", retire_cnt, 0);
        step(3);
        chk("idle_imem_req", bus.imem_req, 0);
        chk("idle_halted", halted, 0);

        // 2: straight-line instruction, no branch
        start = 1'b1; step(); start = 1'b0;
        chk("t2_fetch_req", bus.imem_req, 1);
        bus.imem_ack = 1'b1; bus.imem_data = 8'h12; step(); bus.imem_ack = 1'b0;
        chk("t2_ir", bus.ir, 8'h12);
        chk("t2_decode_req", bus.imem_req, 0);
        chk("t2_decode_pc_en", bus.pc_en, 0);
        step();
        chk("t2_exec_valid", bus.exec_valid, 1);
        bus.exec_done = 1'b1; bus.br_taken = 1'b0; step(); bus.exec_done = 1'b0;
        chk("t2_upd_pc_en", bus.pc_en, 1);
        chk("t2_upd_pc_load", bus.pc_load, 0);
        chk("t2_upd_exec_valid", bus.exec_valid, 0);
        step();
        chk("t2_pc_en_drop", bus.pc_en, 0);
        chk("t2_retire", retire_cnt, 1);
        chk("t2_refetch", bus.imem_req, 1);

        // 3: taken branch to 4'hA
        bus.imem_ack = 1'b1; bus.imem_data = 8'h34; step(); bus.imem_ack = 1'b0;
        chk("t3_ir", bus.ir, 8'h34);
        step();
        bus.exec_done = 1'b1; bus.br_taken = 1'b1; bus.br_tgt = 4'hA;
        step();
        bus.exec_done = 1'b0; bus.br_taken = 1'b0; bus.br_tgt = 4'h0;
        chk("t3_pc_load", bus.pc_load, 1);
        chk("t3_pc_tgt", bus.pc_tgt, 4'hA);
        chk("t3_pc_en", bus.pc_en, 0);
        step();
        chk("t3_retire", retire_cnt, 2);
        chk("t3_pc_load_drop", bus.pc_load, 0);

        // 4: HALT opcode
        bus.imem_ack = 1'b1; bus.imem_data = 8'hF0; step(); bus.imem_ack = 1'b0;
        step();
        chk("t4_halted", halted, 1);
        chk("t4_exec_valid", bus.exec_valid, 0);
        chk("t4_pc_en", bus.pc_en, 0);
        chk("t4_pc_load", bus.pc_load, 0);
        step();
        chk("t4_retire", retire_cnt, 2);
        chk("t4_no_req", bus.imem_req, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("t4_restart_req", bus.imem_req, 1);
        chk("t4_restart_halted", halted, 0);

        // 5: halt request during a slow execute
        bus.imem_ack = 1'b1; bus.imem_data = 8'h56; step(); bus.imem_ack = 1'b0;
        step();
        chk("t5_exec_valid", bus.exec_valid, 1);
        halt_req = 1'b1; step(); halt_req = 1'b0;
        step(2);
        chk("t5_exec_held", bus.exec_valid, 1);
        bus.exec_done = 1'b1; step(); bus.exec_done = 1'b0;
        chk("t5_pc_en", bus.pc_en, 1);
        step();
        chk("t5_halted", halted, 1);
        chk("t5_no_req", bus.imem_req, 0);
        chk("t5_retire", retire_cnt, 3);
        step(2);
        chk("t5_still_no_req", bus.imem_req, 0);

        // 6: reset mid-fetch with a simultaneous ack, then a late exec_done
        start = 1'b1; step(); start = 1'b0;
        chk("t6_fetch_req", bus.imem_req, 1);
        rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_data = 8'h77;
        step();
        rst = 1'b0; bus.imem_ack = 1'b0;
        chk("t6_req_drop", bus.imem_req, 0);
        chk("t6_ir_clear", bus.ir, 0);
        chk("t6_retire_clear", retire_cnt, 0);
        bus.exec_done = 1'b1; bus.br_taken = 1'b1; bus.br_tgt = 4'h5;
        step();
        bus.exec_done = 1'b0; bus.br_taken = 1'b0; bus.br_tgt = 4'h0;
        chk("t6_late_exec_valid", bus.exec_valid, 0);
        chk("t6_late_pc_load", bus.pc_load, 0);
        chk("t6_late_pc_tgt", bus.pc_tgt, 0);
        chk("t6_idle_req", bus.imem_req, 0);

        // Saturation on the 3-bit instance: 4 cycles per instruction.
        start_s = 1'b1; step(); start_s = 1'b0;
        step(4);
        chk("sat_one", retire_cnt_s, 1);
        step(24);
        chk("sat_seven", retire_cnt_s, 7);
        step(12);
        chk("sat_hold", retire_cnt_s, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
